flex_stp_word_rx: RTL and testbench
===================================

FLEX_STP_WORD_RX -- requirements
Module: flex_stp_word_rx

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8: word width, legal range 2..32.
REQ-002 SHALL have parameter SHIFT_MSB, default 0: 1 = first bit lands in MSB, 0 = first bit lands in LSB.
REQ-003 SHALL have port clk, input, 1: clock, rising-edge active.
REQ-004 SHALL have port n_rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port shift_enable, input, 1: serial_in is sampled this edge.
REQ-006 SHALL have port serial_in, input, 1: serial data bit.
REQ-007 SHALL have port clear, input, 1: synchronous abort and flush.
REQ-008 SHALL have port word_ready, input, 1: consumer accepts the held word.
REQ-009 SHALL have port parallel_out, output, NUM_BITS: held word.
REQ-010 SHALL have port word_valid, output, 1: parallel_out holds an unconsumed word.
REQ-011 SHALL have port overflow, output, 1: sticky, a completed word was dropped.
REQ-012 SHALL have port stuff_err, output, 1: one-cycle pulse on a bit-stuff violation.

Function
REQ-013 SHALL, on an accepted bit, shift it into an internal shift register, direction per SHIFT_MSB, and increment the bit counter (width $clog2(NUM_BITS)).
REQ-014 SHALL treat a cycle with shift_enable=0 as a hold: no shift, no count change.
REQ-015 SHALL, on the edge accepting bit NUM_BITS, load the assembled word into parallel_out, set word_valid the next cycle, and wrap the bit counter to 0.
REQ-016 SHALL consume the held word on an edge where word_valid=1 and word_ready=1; word_valid then falls unless a new word completes on the same edge.
REQ-017 SHALL, when a word completes on the same edge as a consume, load the new word and keep word_valid=1 with no overflow.
REQ-018 SHALL, when a word completes while word_valid=1 and word_ready=0, keep the old parallel_out, drop the new word, and set overflow.
REQ-019 SHALL keep overflow set until clear or reset.
REQ-020 SHALL give clear priority over shift_enable and word_ready: bit counter 0, shift register all-ones, word_valid 0, overflow 0, unstuff state idle; serial_in is ignored that cycle.
REQ-021 SHALL leave parallel_out unchanged on clear.

Reset
REQ-022 SHALL, on n_rst low, immediately force parallel_out=0, shift register all-ones, bit counter 0, word_valid 0, overflow 0, stuff_err 0, and ones-run counter 0.
REQ-023 SHALL discard any partial word on reset mid-operation; the first accepted bit after release is bit 0 of a new word.

Configuration
REQ-024 SHALL implement USB bit-unstuffing only when macro FLEX_STP_BITSTUFF_EN is defined.
REQ-025 SHALL, with FLEX_STP_BITSTUFF_EN defined, count consecutive accepted 1s across word boundaries; after 6, the next accepted bit is a stuff bit that is neither shifted nor counted, and the run count resets.
REQ-026 SHALL, with FLEX_STP_BITSTUFF_EN defined, pulse stuff_err for one cycle when the stuff bit is 1, and reset the bit counter to 0, discarding the partial word.
REQ-027 SHALL, without FLEX_STP_BITSTUFF_EN, keep the stuff_err port tied to 0 and shift every accepted bit.

Structure
REQ-028 SHALL take STUFF_RUN_LEN (=6) and the unstuff state enum (UNSTUFF_RUN, UNSTUFF_SKIP) from package flex_stp_pkg.
REQ-029 SHALL place run counting and stuff-bit detection in sub-module flex_stp_unstuff, instantiated only under FLEX_STP_BITSTUFF_EN.

Verification
REQ-030 SHALL cover: NUM_BITS=8, SHIFT_MSB=0, bits 1,0,1,1,0,0,1,0 with word_ready=1 -> parallel_out=0x4D and word_valid high for exactly 1 cycle.
REQ-031 SHALL cover: the same bits with SHIFT_MSB=1 -> parallel_out=0xB2.
REQ-032 SHALL cover: word_ready=0, send 0x4D then 0x00 -> parallel_out stays 0x4D, overflow=1; then clear -> word_valid=0, overflow=0.
REQ-033 SHALL cover: 5 bits then clear, then 8 zero bits -> single word 0x00, no overflow.
REQ-034 SHALL cover: FLEX_STP_BITSTUFF_EN defined, 1×6, 0, 1,1 -> 0xFF after 9 accepted bits; 1×7 -> stuff_err pulse on the 7th bit and bit counter 0.
REQ-035 SHALL cover: n_rst low after bit 4 -> all outputs at reset values; the next 8 bits form a clean word.

Source files
------------

// File: rtl/flex_stp_pkg.sv
// Shared definitions for the flex_stp serial word receiver.
// Holds the bit-stuff run length and the unstuff FSM state encoding.
package flex_stp_pkg;

   // Number of consecutive 1s after which the next bit is a stuff bit
   localparam int STUFF_RUN_LEN = 6;

   // Width of the ones-run counter, wide enough to hold STUFF_RUN_LEN
   localparam int RUN_W = $clog2(STUFF_RUN_LEN + 1);

   typedef enum logic {
      UNSTUFF_RUN  = 1'b0,
      UNSTUFF_SKIP = 1'b1
   } unstuff_state_t;

endpackage

// File: rtl/flex_stp_unstuff.sv
// USB-style bit-unstuffing tracker for flex_stp_word_rx.
// Counts consecutive accepted 1s; once STUFF_RUN_LEN is reached, the next
// accepted bit is a stuff bit. The current state is exported so the parent
// can skip that bit, and a registered one-cycle stuff_err pulse flags a
// stuff bit that arrived as 1.
import flex_stp_pkg::*;

module flex_stp_unstuff (
   input  logic           clk,
   input  logic           n_rst,
   input  logic           clear,
   input  logic           bit_valid,
   input  logic           bit_in,
   output logic           stuff_err,
   output unstuff_state_t state
);

   unstuff_state_t       state_q;
   unstuff_state_t       state_d;
   logic [RUN_W-1:0]     run_q;
   logic [RUN_W-1:0]     run_d;
   logic                 err_d;

   assign state = state_q;

   // Next-state logic: track the ones run and consume the stuff bit
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      err_d   = 1'b0;
      if (clear) begin
         state_d = UNSTUFF_RUN;
         run_d   = '0;
      end else if (bit_valid) begin
         case (state_q)
            UNSTUFF_RUN: begin
               if (bit_in) begin
                  run_d = run_q + 1'b1;
                  if (run_q == RUN_W'(STUFF_RUN_LEN - 1)) begin
                     state_d = UNSTUFF_SKIP;
                  end
               end else begin
                  run_d = '0;
               end
            end
            UNSTUFF_SKIP: begin
               // Stuff bit: never data, restarts the run, must be 0
               run_d   = '0;
               err_d   = bit_in;
               state_d = UNSTUFF_RUN;
            end
            default: begin
               state_d = UNSTUFF_RUN;
               run_d   = '0;
            end
         endcase
      end
   end

   // State, run counter and error pulse registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= UNSTUFF_RUN;
         run_q     <= '0;
         stuff_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         stuff_err <= err_d;
      end
   end

endmodule

// File: rtl/flex_stp_word_rx.sv
// Serial-to-parallel word receiver with a one-word holding register.
// Bits accepted on shift_enable are assembled into NUM_BITS-wide words
// (first bit in LSB when SHIFT_MSB=0, in MSB when SHIFT_MSB=1). A completed
// word is offered on parallel_out/word_valid; a word completing while the
// previous one is still unconsumed is dropped and flagged by sticky overflow.
// Optional USB bit-unstuffing is enabled by defining FLEX_STP_BITSTUFF_EN.
//
// Handshake: word_valid=1 means parallel_out holds an unconsumed word; the
// word is consumed on any rising edge where word_valid=1 and word_ready=1.
// word_valid never drops without a consume, clear or reset, and
// parallel_out does not change while word_valid=1 and the word is unconsumed.
import flex_stp_pkg::*;

module flex_stp_word_rx #(
   parameter int NUM_BITS  = 8,
   parameter int SHIFT_MSB = 0
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                shift_enable,
   input  logic                serial_in,
   input  logic                clear,
   input  logic                word_ready,
   output logic [NUM_BITS-1:0] parallel_out,
   output logic                word_valid,
   output logic                overflow,
   output logic                stuff_err
);

   localparam int CNT_W = $clog2(NUM_BITS);

   logic [NUM_BITS-1:0] sr_q;
   logic [NUM_BITS-1:0] sr_next;
   logic [CNT_W-1:0]    cnt_q;
   logic                accept;
   logic                skip_bit;
   logic                stuff_hit;
   logic                take_bit;
   logic                done;
   logic                consume;

   // clear wins over everything, so a bit is only accepted outside clear
   assign accept = shift_enable & ~clear;

`ifdef FLEX_STP_BITSTUFF_EN
   unstuff_state_t unstuff_state;

   flex_stp_unstuff u_unstuff (
      .clk       (clk),
      .n_rst     (n_rst),
      .clear     (clear),
      .bit_valid (accept),
      .bit_in    (serial_in),
      .stuff_err (stuff_err),
      .state     (unstuff_state)
   );

   assign skip_bit  = accept & (unstuff_state == UNSTUFF_SKIP);
   assign stuff_hit = skip_bit & serial_in;
`else
   assign skip_bit  = 1'b0;
   assign stuff_hit = 1'b0;
   assign stuff_err = 1'b0;
`endif

   assign take_bit = accept & ~skip_bit;
   assign done     = take_bit & (cnt_q == CNT_W'(NUM_BITS - 1));
   assign consume  = word_valid & word_ready;

   // Shift direction decides where the first bit ends up after NUM_BITS shifts
   assign sr_next = (SHIFT_MSB != 0) ? {sr_q[NUM_BITS-2:0], serial_in}
                                     : {serial_in, sr_q[NUM_BITS-1:1]};

   // Shift register and bit counter
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sr_q  <= '1;
         cnt_q <= '0;
      end else if (clear) begin
         sr_q  <= '1;
         cnt_q <= '0;
      end else if (stuff_hit) begin
         // Stuff violation: drop the partial word and restart framing
         cnt_q <= '0;
      end else if (take_bit) begin
         sr_q  <= sr_next;
         cnt_q <= done ? '0 : cnt_q + 1'b1;
      end
   end

   // Holding register, valid flag and sticky overflow
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         parallel_out <= '0;
         word_valid   <= 1'b0;
         overflow     <= 1'b0;
      end else if (clear) begin
         word_valid   <= 1'b0;
         overflow     <= 1'b0;
      end else if (done) begin
         if (!word_valid || word_ready) begin
            parallel_out <= sr_next;
            word_valid   <= 1'b1;
         end else begin
            overflow     <= 1'b1;
         end
      end else if (consume) begin
         word_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_flex_stp_word_rx.sv
// Self-checking bench for flex_stp_word_rx: two instances (LSB-first and
// MSB-first) share one stimulus stream and are compared every cycle against
// a bit-list model of the receiver, plus literal expectations for key cases.
module tb_flex_stp_word_rx;

  logic       clk;
  logic       n_rst;
  logic       shift_enable;
  logic       serial_in;
  logic       clear;
  logic       word_ready;
  logic [7:0] po_l, po_m;
  logic       wv_l, wv_m, ov_l, ov_m, se_l, se_m;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int         m_nbits;
  bit         m_bits[8];
  logic [7:0] m_po_l, m_po_m;
  bit         m_valid, m_ovf, m_err;
  int         m_run;
  bit         m_skip;

  flex_stp_word_rx #(.NUM_BITS(8), .SHIFT_MSB(0)) dut_lsb (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .word_ready(word_ready), .parallel_out(po_l),
    .word_valid(wv_l), .overflow(ov_l), .stuff_err(se_l)
  );

  flex_stp_word_rx #(.NUM_BITS(8), .SHIFT_MSB(1)) dut_msb (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .word_ready(word_ready), .parallel_out(po_m),
    .word_valid(wv_m), .overflow(ov_m), .stuff_err(se_m)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_nbits = 0;
    m_po_l  = 8'h00;
    m_po_m  = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_err   = 1'b0;
    m_run   = 0;
    m_skip  = 1'b0;
  endtask

  // Apply one cycle of inputs and advance the model at the rising edge
  task automatic step(input bit se, input bit si, input bit clr, input bit rdy);
    bit done, consume;
    logic [7:0] wl, wm;
    @(negedge clk);
    shift_enable = se;
    serial_in    = si;
    clear        = clr;
    word_ready   = rdy;
    @(posedge clk);
    consume = m_valid && rdy;
    done    = 1'b0;
    wl      = 8'h00;
    wm      = 8'h00;
    if (clr) begin
      m_nbits = 0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_err   = 1'b0;
      m_run   = 0;
      m_skip  = 1'b0;
    end else begin
      m_err = 1'b0;
      if (se) begin
`ifdef FLEX_STP_BITSTUFF_EN
        if (m_skip) begin
          m_skip = 1'b0;
          m_run  = 0;
          if (si) begin
            m_err   = 1'b1;
            m_nbits = 0;
          end
        end else begin
          m_bits[m_nbits] = si;
          m_nbits++;
          m_run = si ? m_run + 1 : 0;
          if (m_run == 6) m_skip = 1'b1;
        end
`else
        m_bits[m_nbits] = si;
        m_nbits++;
`endif
        if (m_nbits == 8) begin
          done = 1'b1;
          for (int i = 0; i < 8; i++) begin
            wl[i]     = m_bits[i];
            wm[7 - i] = m_bits[i];
          end
          m_nbits = 0;
        end
      end
      if (done) begin
        if (!m_valid || consume) begin
          m_po_l  = wl;
          m_po_m  = wm;
          m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (consume) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rdy);
    for (int i = 0; i < 8; i++) step(1'b1, b[i], 1'b0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    m_reset();
    shift_enable = 1'b0;
    clear        = 1'b0;
    word_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Compare process: DUT outputs against the model every cycle
  always @(negedge clk) begin
    check("po_lsb", {24'h0, po_l}, {24'h0, m_po_l});
    check("po_msb", {24'h0, po_m}, {24'h0, m_po_m});
    check("valid_lsb", {31'h0, wv_l}, {31'h0, m_valid});
    check("valid_msb", {31'h0, wv_m}, {31'h0, m_valid});
    check("ovf_lsb", {31'h0, ov_l}, {31'h0, m_ovf});
    check("ovf_msb", {31'h0, ov_m}, {31'h0, m_ovf});
    check("err_lsb", {31'h0, se_l}, {31'h0, m_err});
    check("err_msb", {31'h0, se_m}, {31'h0, m_err});
  end

  initial begin
    n_rst        = 1'b0;
    shift_enable = 1'b0;
    serial_in    = 1'b0;
    clear        = 1'b0;
    word_ready   = 1'b0;
    m_reset();
    do_reset();
    #1;
    check("rst_po", {24'h0, po_l}, 32'h0);
    check("rst_valid", {31'h0, wv_l}, 32'h0);
    check("rst_ovf", {31'h0, ov_l}, 32'h0);
    check("rst_err", {31'h0, se_l}, 32'h0);

    // basic word, both shift directions, valid for one cycle
    for (int i = 0; i < 7; i++) step(1'b1, (8'h4D >> i) & 1'b1, 1'b0, 1'b1);
    #1 check("lit_valid_before", {31'h0, wv_l}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    check("lit_word_lsb", {24'h0, po_l}, 32'h4D);
    check("lit_word_msb", {24'h0, po_m}, 32'hB2);
    check("lit_valid_hi", {31'h0, wv_l}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    #1 check("lit_valid_one_cycle", {31'h0, wv_l}, 32'h0);

    // overflow: second word dropped while first is unconsumed
    send_byte(8'h4D, 1'b0);
    send_byte(8'h00, 1'b0);
    #1;
    check("lit_ovf_hold", {24'h0, po_l}, 32'h4D);
    check("lit_ovf_set", {31'h0, ov_l}, 32'h1);
    check("lit_ovf_valid", {31'h0, wv_l}, 32'h1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    check("lit_clr_valid", {31'h0, wv_l}, 32'h0);
    check("lit_clr_ovf", {31'h0, ov_l}, 32'h0);
    check("lit_clr_po", {24'h0, po_l}, 32'h4D);

    // partial word flushed by clear
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0);
    #1;
    check("lit_flush_word", {24'h0, po_l}, 32'h00);
    check("lit_flush_valid", {31'h0, wv_l}, 32'h1);
    check("lit_flush_ovf", {31'h0, ov_l}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef FLEX_STP_BITSTUFF_EN
    // six ones, stuffed zero, two ones -> all-ones word
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    #1 check("lit_stuff_pending", {31'h0, wv_l}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    check("lit_stuff_word", {24'h0, po_l}, 32'hFF);
    check("lit_stuff_valid", {31'h0, wv_l}, 32'h1);
    // seven ones -> stuff error, partial word discarded
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    #1 check("lit_stuff_err", {31'h0, se_l}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    #1 check("lit_stuff_err_pulse", {31'h0, se_l}, 32'h0);
    send_byte(8'h96, 1'b1);
    #1 check("lit_after_err", {24'h0, po_l}, 32'h96);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // asynchronous reset mid-word, then a clean word
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    #3;
    n_rst = 1'b0;
    m_reset();
    #1;
    check("lit_arst_po", {24'h0, po_l}, 32'h0);
    check("lit_arst_valid", {31'h0, wv_l}, 32'h0);
    check("lit_arst_ovf", {31'h0, ov_l}, 32'h0);
    check("lit_arst_err", {31'h0, se_l}, 32'h0);
    shift_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    send_byte(8'h96, 1'b1);
    #1;
    check("lit_post_rst_lsb", {24'h0, po_l}, 32'h96);
    check("lit_post_rst_msb", {24'h0, po_m}, 32'h69);

    // randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
